fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Downstream drain stage for the synchronous FIFO. Issues `rd_en` to the FIFO while it is non-empty and local space exists, then captures the registered `data_out` one cycle later into a 2-entry skid buffer. Presents the words as a valid/ready stream to the consumer. Also keeps a delivered-word counter and a sticky underflow error flag.

## Interface
Parameters:
- `FIFO_WIDTH`, 16, data word width; matches the FIFO.
- `CNT_WIDTH`, 16, width of the delivered-word counter.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  permits new FIFO reads.
- `fifo_empty`  in  1  FIFO `empty`.
- `fifo_underflow`  in  1  FIFO `underflow`.
- `fifo_data_out`  in  FIFO_WIDTH  FIFO `data_out`; valid the cycle after `rd_en`.
- `fifo_rd_en`  out  1  FIFO `rd_en`.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  consumer accepts the word.
- `m_data`  out  FIFO_WIDTH  output word.
- `rd_count`  out  CNT_WIDTH  count of delivered words.
- `err_underflow`  out  1  sticky; a read returned underflow.

## Operation
- **State:** buffer occupancy `occ` ∈ {0, 1, 2}, encoded as `EMPTY`, `ONE`, `TWO`. `inflight` register is `fifo_rd_en` delayed one cycle.
- **pop** = `m_valid && m_ready`.
- **Read issue:** `fifo_rd_en = enable && !fifo_empty && (occ + inflight - pop < 2)`.
  - This path is combinational from `m_ready` and `fifo_empty`.
  - Guarantees the buffer never overflows.
- **Capture:** when `inflight && !fifo_underflow`, write `fifo_data_out` at the tail.
  - When `inflight && fifo_underflow`, discard the data and set `err_underflow`. It stays 1 until reset.
- **Output:**
  - `m_valid = (occ != 0)`.
  - `m_data` = head entry; held stable while `m_valid && !m_ready`.
  - Order is strictly FIFO.
- **Occupancy transitions:**
  - capture only: `occ`+1.
  - pop only: `occ`−1.
  - capture and pop together: `occ` unchanged; head advances, tail written.
  - Capture with pop at `occ`=2 is impossible by construction.
- **Counter:** `rd_count` +1 on each pop. Wraps modulo 2^CNT_WIDTH with no saturation.
- **`enable` low:** no new `fifo_rd_en`. The in-flight word still lands, and buffered words still drain.
- **Reset** (asynchronous, any time):
  - `occ`=0, `inflight`=0, `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `rd_count`=0, `err_underflow`=0.
  - An in-flight word is dropped. The FIFO shares `rst_n`, so nothing is lost.

## Timing
- **Latency:** 2 cycles from FIFO non-empty to `m_valid`. `fifo_rd_en` rises in cycle N, capture happens at edge N+1, `m_valid` is high in cycle N+2.
- **Throughput:** one word per cycle sustained while `m_ready`=1 and the FIFO is non-empty.
- **Backpressure:** with `m_ready` held low, at most 2 reads are issued. Reads resume the same cycle `m_ready` rises (credit includes pop).
- **`fifo_empty` rising:** reads stop the same cycle.

## Structure
- Package `fifo_pkg`: `FIFO_WIDTH`/`FIFO_DEPTH` defaults and typedef `occ_t` (enum `EMPTY`/`ONE`/`TWO`). The FIFO, its interface and this block share it.
- Sub-module `fifo_skid_buf`: 2-entry buffer holding `occ`, the head/tail pointers, and push/pop/data ports.
- Top level holds the credit logic, `inflight`, the counter and the error flag.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream.
  - All outputs read 0 immediately (asynchronous).
  - After release, no stray `m_valid`.
- **Streaming:** FIFO loaded with 0x00A1, 0x00A2, 0x00A3; `m_ready`=1.
  - `fifo_rd_en` high for 3 consecutive cycles.
  - `m_valid` high for 3 consecutive cycles starting 2 cycles later, with data in order.
  - `rd_count`=3.
- **Backpressure:** FIFO holds 5 words; `m_ready`=0.
  - Exactly 2 `fifo_rd_en` pulses; `m_data` stable at word 0.
  - Raise `m_ready`: all 5 delivered in order with no gaps; `rd_count`=5.
- **Error injection:** force `fifo_underflow`=1 in the cycle after a read.
  - `err_underflow`=1 and stays 1; that slot produces no `m_valid`.
  - Subsequent words are still delivered.
- **Enable gating:** `enable`=0 with a non-empty FIFO produces no reads.
  - Dropping `enable` during streaming: the in-flight word is still delivered, then `m_valid` falls.
- **Counter wrap:** with `CNT_WIDTH`=4, deliver 17 words; `rd_count`=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the synchronous FIFO and its drain stage:
// default data width / depth and the skid-buffer occupancy encoding.
// ----------------------------------------------------------------------------
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH = 16;
    localparam int unsigned FIFO_DEPTH = 16;

    // Occupancy of the 2-entry skid buffer
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// ----------------------------------------------------------------------------
// fifo_skid_buf
// Two-entry in-order buffer with registered head word and valid flag.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_push         write i_push_data at the tail this cycle
//   i_push_data    word to write
//   i_pop          retire the head word (only while o_valid)
//   o_valid        buffer holds at least one word
//   o_data         head word, stable until popped
//   o_occ          current occupancy
// ----------------------------------------------------------------------------
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output occ_t             o_occ
);

    occ_t             r_occ;
    occ_t             w_occ_nxt;
    logic             r_head;
    logic             r_tail;
    logic [WIDTH-1:0] r_mem [2];
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;
    logic             r_valid;

    // Next occupancy
    always_comb begin
        w_occ_nxt = r_occ;
        case ({i_push, i_pop})
            2'b10: begin
                case (r_occ)
                    EMPTY:   w_occ_nxt = ONE;
                    default: w_occ_nxt = TWO;
                endcase
            end
            2'b01: begin
                case (r_occ)
                    TWO:     w_occ_nxt = ONE;
                    default: w_occ_nxt = EMPTY;
                endcase
            end
            default: w_occ_nxt = r_occ;
        endcase
    end

    // Next head word, kept in its own register so o_data needs no read mux
    always_comb begin
        w_data_nxt = r_data;
        if (i_pop) begin
            if (r_occ == TWO) begin
                w_data_nxt = r_mem[~r_head];
            end else if (i_push) begin
                w_data_nxt = i_push_data;
            end
        end else if (r_occ == EMPTY && i_push) begin
            w_data_nxt = i_push_data;
        end
    end

    // Storage, pointers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ    <= EMPTY;
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_occ   <= w_occ_nxt;
            r_valid <= (w_occ_nxt != EMPTY);
            r_data  <= w_data_nxt;
            if (i_push) begin
                r_mem[r_tail] <= i_push_data;
                r_tail        <= ~r_tail;
            end
            if (i_pop) begin
                r_head <= ~r_head;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_occ   = r_occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// ----------------------------------------------------------------------------
// fifo_stream_reader
// Drains a synchronous FIFO (1-cycle read latency) into a valid/ready stream
// through a 2-entry skid buffer; counts delivered words and flags underflow.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   enable           permits new FIFO reads
//   fifo_empty       FIFO empty flag
//   fifo_underflow   FIFO underflow flag, aligned with fifo_data_out
//   fifo_data_out    FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en       FIFO read strobe (combinational credit check)
//   m_valid/m_ready  output stream handshake
//   m_data           output word
//   rd_count         delivered-word counter, wraps
//   err_underflow    sticky underflow flag
// ----------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  err_underflow
);

    import fifo_pkg::*;

    occ_t                  w_occ;
    logic                  w_valid;
    logic [FIFO_WIDTH-1:0] w_data;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_rd_en;
    logic [2:0]            w_level;
    logic                  r_inflight;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_err;

    assign w_pop   = w_valid & m_ready;
    assign w_push  = r_inflight & ~fifo_underflow;

    // Committed slots = buffered + in flight; a same-cycle pop frees one
    assign w_level = {1'b0, w_occ} + {2'b00, r_inflight};
    assign w_rd_en = rst_n & enable & ~fifo_empty
                   & (w_level < (3'd2 + {2'b00, w_pop}));

    fifo_skid_buf #(
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (fifo_data_out),
        .i_pop       (w_pop),
        .o_valid     (w_valid),
        .o_data      (w_data),
        .o_occ       (w_occ)
    );

    // Read tracking, delivered count and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_pop) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
            if (r_inflight && fifo_underflow) begin
                r_err <= 1'b1;
            end
        end
    end

    assign fifo_rd_en    = w_rd_en;
    assign m_valid       = w_valid;
    assign m_data        = w_data;
    assign rd_count      = r_count;
    assign err_underflow = r_err;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// ----------------------------------------------------------------------------
// tb_fifo_stream_reader
// Directed bench: a behavioural 1-cycle-latency FIFO feeds the DUT; each
// scenario task drives inputs at the falling edge and samples 1 ns later.
// ----------------------------------------------------------------------------
module tb_fifo_stream_reader;

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          fifo_empty;
    logic          fifo_underflow;
    logic [W-1:0]  fifo_data_out;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic [CW-1:0] rd_count;
    logic          err_underflow;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural FIFO
    logic [W-1:0] fmem [32];
    int           wr_ptr  = 0;
    int           rd_ptr  = 0;
    logic         inj_arm = 1'b0;

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr         <= wr_ptr;
            fifo_data_out  <= '0;
            fifo_underflow <= 1'b0;
        end else begin
            fifo_underflow <= 1'b0;
            if (fifo_rd_en) begin
                fifo_data_out  <= fmem[rd_ptr % 32];
                rd_ptr         <= rd_ptr + 1;
                fifo_underflow <= inj_arm;
            end
        end
    end

    fifo_stream_reader #(
        .FIFO_WIDTH (W),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_data_out  (fifo_data_out),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .rd_count       (rd_count),
        .err_underflow  (err_underflow)
    );

    task automatic load(input logic [W-1:0] w);
        fmem[wr_ptr % 32] = w;
        wr_ptr++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        inj_arm = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_total++; if (m_valid !== 1'b0) $display("FAIL por_m_valid got %b exp 0", m_valid); else n_pass++;
        n_total++; if (m_data !== 16'h0) $display("FAIL por_m_data got %h exp 0000", m_data); else n_pass++;
        n_total++; if (rd_count !== 4'h0) $display("FAIL por_rd_count got %h exp 0", rd_count); else n_pass++;
        n_total++; if (err_underflow !== 1'b0) $display("FAIL por_err got %b exp 0", err_underflow); else n_pass++;
        n_total++; if (fifo_rd_en !== 1'b0) $display("FAIL por_rd_en got %b exp 0", fifo_rd_en); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        // Mid-stream reset
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
                enable  = 1'b1;
                m_ready = 1'b1;
                load(16'h0051); load(16'h0052); load(16'h0053);
            end
            #1;
        end
        n_total++; if (m_valid !== 1'b1) $display("FAIL pre_rst_valid got %b exp 1", m_valid); else n_pass++;
        n_total++; if (rd_count !== 4'h1) $display("FAIL pre_rst_count got %h exp 1", rd_count); else n_pass++;
        #1;
        rst_n = 1'b0;
        #1;
        n_total++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid got %b exp 0", m_valid); else n_pass++;
        n_total++; if (m_data !== 16'h0) $display("FAIL rst_m_data got %h exp 0000", m_data); else n_pass++;
        n_total++; if (rd_count !== 4'h0) $display("FAIL rst_rd_count got %h exp 0", rd_count); else n_pass++;
        n_total++; if (fifo_rd_en !== 1'b0) $display("FAIL rst_rd_en got %b exp 0", fifo_rd_en); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_total++; if (m_valid !== 1'b0) $display("FAIL post_rst_valid c%0d got %b exp 0", c, m_valid); else n_pass++;
        end
    endtask

    task automatic test_streaming();
        logic [7:0]   exp_rd;
        logic [7:0]   exp_v;
        logic [W-1:0] exp_d [8];
        exp_rd = 8'b0000_0111;
        exp_v  = 8'b0001_1100;
        exp_d[2] = 16'h00A1; exp_d[3] = 16'h00A2; exp_d[4] = 16'h00A3;
        do_reset();
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                load(16'h00A1); load(16'h00A2); load(16'h00A3);
            end
            #1;
            n_total++; if (fifo_rd_en !== exp_rd[c]) $display("FAIL stream_rd_en c%0d got %b exp %b", c, fifo_rd_en, exp_rd[c]); else n_pass++;
            n_total++; if (m_valid !== exp_v[c]) $display("FAIL stream_valid c%0d got %b exp %b", c, m_valid, exp_v[c]); else n_pass++;
            if (exp_v[c]) begin
                n_total++; if (m_data !== exp_d[c]) $display("FAIL stream_data c%0d got %h exp %h", c, m_data, exp_d[c]); else n_pass++;
            end
        end
        n_total++; if (rd_count !== 4'd3) $display("FAIL stream_count got %0d exp 3", rd_count); else n_pass++;
    endtask

    task automatic test_backpressure();
        int           pulses;
        logic [W-1:0] exp_w;
        pulses = 0;
        do_reset();
        enable  = 1'b1;
        m_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                for (int i = 0; i < 5; i++) load(16'h00C0 + 16'(i));
            end
            #1;
            if (fifo_rd_en) pulses++;
            if (c >= 2) begin
                n_total++; if (m_valid !== 1'b1 || m_data !== 16'h00C0) $display("FAIL bp_hold c%0d got v=%b d=%h exp v=1 d=00c0", c, m_valid, m_data); else n_pass++;
            end
        end
        n_total++; if (pulses !== 2) $display("FAIL bp_pulses got %0d exp 2", pulses); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) m_ready = 1'b1;
            #1;
            exp_w = 16'h00C0 + 16'(k);
            n_total++; if (m_valid !== 1'b1 || m_data !== exp_w) $display("FAIL bp_drain k%0d got v=%b d=%h exp v=1 d=%h", k, m_valid, m_data, exp_w); else n_pass++;
            if (k == 0) begin
                n_total++; if (fifo_rd_en !== 1'b1) $display("FAIL bp_resume got %b exp 1", fifo_rd_en); else n_pass++;
            end
        end
        @(negedge clk); #1;
        n_total++; if (m_valid !== 1'b0) $display("FAIL bp_end_valid got %b exp 0", m_valid); else n_pass++;
        n_total++; if (rd_count !== 4'd5) $display("FAIL bp_count got %0d exp 5", rd_count); else n_pass++;
    endtask

    task automatic test_underflow();
        logic [6:0]   exp_v;
        logic [W-1:0] exp_d [7];
        exp_v = 7'b001_1000;
        exp_d[3] = 16'h00B2; exp_d[4] = 16'h00B3;
        do_reset();
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 0) begin
                inj_arm = 1'b1;
                load(16'h00B1); load(16'h00B2); load(16'h00B3);
            end
            if (c == 1) inj_arm = 1'b0;
            #1;
            n_total++; if (m_valid !== exp_v[c]) $display("FAIL uf_valid c%0d got %b exp %b", c, m_valid, exp_v[c]); else n_pass++;
            if (exp_v[c]) begin
                n_total++; if (m_data !== exp_d[c]) $display("FAIL uf_data c%0d got %h exp %h", c, m_data, exp_d[c]); else n_pass++;
            end
            if (c >= 2) begin
                n_total++; if (err_underflow !== 1'b1) $display("FAIL uf_err c%0d got %b exp 1", c, err_underflow); else n_pass++;
            end
        end
        n_total++; if (rd_count !== 4'd2) $display("FAIL uf_count got %0d exp 2", rd_count); else n_pass++;
    endtask

    task automatic test_enable();
        logic [3:0] exp_rd;
        logic [3:0] exp_v;
        exp_rd = 4'b0001;
        exp_v  = 4'b0100;
        do_reset();
        enable  = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
                load(16'h00E0); load(16'h00E1);
            end
            #1;
            n_total++; if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0) $display("FAIL en_off c%0d got rd=%b v=%b exp 0 0", c, fifo_rd_en, m_valid); else n_pass++;
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            enable = (c == 0);
            #1;
            n_total++; if (fifo_rd_en !== exp_rd[c]) $display("FAIL en_rd c%0d got %b exp %b", c, fifo_rd_en, exp_rd[c]); else n_pass++;
            n_total++; if (m_valid !== exp_v[c]) $display("FAIL en_valid c%0d got %b exp %b", c, m_valid, exp_v[c]); else n_pass++;
            if (exp_v[c]) begin
                n_total++; if (m_data !== 16'h00E0) $display("FAIL en_data got %h exp 00e0", m_data); else n_pass++;
            end
        end
        n_total++; if (rd_count !== 4'd1) $display("FAIL en_count got %0d exp 1", rd_count); else n_pass++;
    endtask

    task automatic test_counter_wrap();
        int           got;
        logic [W-1:0] exp_w;
        got = 0;
        do_reset();
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) begin
                for (int i = 0; i < 17; i++) load(16'h0100 + 16'(i));
            end
            #1;
            if (m_valid) begin
                exp_w = 16'h0100 + 16'(got);
                n_total++; if (m_data !== exp_w) $display("FAIL wrap_data n%0d got %h exp %h", got, m_data, exp_w); else n_pass++;
                got++;
            end
        end
        n_total++; if (got !== 17) $display("FAIL wrap_words got %0d exp 17", got); else n_pass++;
        n_total++; if (rd_count !== 4'd1) $display("FAIL wrap_count got %0d exp 1", rd_count); else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        m_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_underflow();
        test_enable();
        test_counter_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
